// File: rtl/mult_div_unit_if.sv
// mult_div_unit_if: operand/control/result bundle between the issue logic and mult_div_unit
//   start/op/busA/busB/mthi/mtlo : requester -> unit
//   busy/done/hi/lo/div_zero     : unit -> requester
interface mult_div_unit_if #(parameter int WIDTH = 32);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] busA;
    logic [WIDTH-1:0] busB;
    logic             mthi;
    logic             mtlo;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             div_zero;
    modport master (output start, op, busA, busB, mthi, mtlo,
                    input  busy, done, hi, lo, div_zero);
    modport slave  (input  start, op, busA, busB, mthi, mtlo,
                    output busy, done, hi, lo, div_zero);
endinterface

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative MULT/MULTU/DIV/DIVU into HI/LO, with MTHI/MTLO writes
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of mult_div_unit_if (start/op/busA/busB/mthi/mtlo in;
//                busy/done/hi/lo/div_zero out)
module mult_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input logic             clk,
    input logic             rst_n,
    mult_div_unit_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, PREP, RUN, FIX} state_t;
    state_t               state, state_nx;
    logic [1:0]           op_q;
    logic [WIDTH-1:0]     a_q, b_q, m, hi_q, lo_q;
    logic [2*WIDTH-1:0]   acc, step, prod;
    logic [CNT_W-1:0]     cnt;
    logic                 done_q, dz_q;
    logic                 is_div, a_neg, b_neg, div_ok;
    logic [WIDTH-1:0]     abs_a, abs_b, quo, rem;
    logic [WIDTH:0]       mul_sum, div_diff;

    assign is_div = op_q[1];
    assign a_neg  = op_q[0] & a_q[WIDTH-1];
    assign b_neg  = op_q[0] & b_q[WIDTH-1];
    // the most negative value negates to itself, which reads correctly as unsigned 2^(WIDTH-1)
    assign abs_a  = a_neg ? -a_q : a_q;
    assign abs_b  = b_neg ? -b_q : b_q;
    // multiply: add multiplicand into the upper half when the low bit is set, then shift right
    assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, acc[0] ? m : '0};
    // divide: shift remainder left pulling in the next dividend bit, subtract divisor if it fits
    assign div_diff = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]} - {1'b0, m};
    assign div_ok   = ~div_diff[WIDTH];
    assign step = is_div
        ? {(div_ok ? div_diff[WIDTH-1:0] : acc[2*WIDTH-2:WIDTH-1]), acc[WIDTH-2:0], div_ok}
        : {mul_sum, acc[WIDTH-1:1]};
    assign prod = (a_neg ^ b_neg) ? -acc : acc;
    assign quo  = (a_neg ^ b_neg) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    assign rem  = a_neg ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = bus.start ? PREP : IDLE;
            PREP:    state_nx = RUN;
            RUN:     state_nx = (cnt == CNT_W'(WIDTH-1)) ? FIX : RUN;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            m      <= '0;
            acc    <= '0;
            cnt    <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            done_q <= 1'b0;
            dz_q   <= 1'b0;
        end else begin
            done_q <= state == FIX;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        op_q <= bus.op;
                        a_q  <= bus.busA;
                        b_q  <= bus.busB;
                        dz_q <= 1'b0;
                    end else begin
                        if (bus.mthi) hi_q <= bus.busA;
                        if (bus.mtlo) lo_q <= bus.busA;
                    end
                end
                PREP: begin
                    m   <= is_div ? abs_b : abs_a;
                    acc <= {{WIDTH{1'b0}}, is_div ? abs_a : abs_b};
                    cnt <= '0;
                end
                RUN: begin
                    acc <= step;
                    cnt <= cnt + 1'b1;
                end
                default: begin
                    if (!is_div) begin
                        hi_q <= prod[2*WIDTH-1:WIDTH];
                        lo_q <= prod[WIDTH-1:0];
                    end else if (b_q == '0) begin
                        hi_q <= a_q;
                        lo_q <= '1;
                        dz_q <= 1'b1;
                    end else begin
                        hi_q <= rem;
                        lo_q <= quo;
                    end
                end
            endcase
        end
    end

    assign bus.busy     = state != IDLE;
    assign bus.done     = done_q;
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;
    assign bus.div_zero = dz_q;
endmodule
